// File: rtl/floo_vc_credit_selection.sv
// floo_vc_credit_selection: per-VC credit counters for one output port plus
// a combinational preferred-VC selector (preferred VC first, else the next
// non-empty VC in wrap-around order).
// Optional feature macro: FLOO_VC_CREDIT_CHECK_EN adds a sticky
// credit underflow/overflow flag on credit_err_o; when undefined the flag
// is tied low and no check state exists.
module floo_vc_credit_selection #(
    parameter int NumVC         = 4,
    parameter int NumVCWidth    = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int NumVCWidthMax = 2,
    parameter int VCDepth       = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  credit_v_i,
    input  logic [NumVCWidthMax-1:0]              credit_id_i,
    input  logic                                  consume_v_i,
    input  logic [NumVCWidthMax-1:0]              consume_id_i,
    output logic [NumVC-1:0]                      vc_selection_v_o,
    output logic [NumVC-1:0][NumVCWidthMax-1:0]   vc_selection_id_o,
    output logic [NumVC-1:0]                      vc_not_empty_o,
    output logic                                  credit_err_o
);

    localparam int CntWidth = $clog2(VCDepth + 1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(VCDepth);

    logic [CntWidth-1:0]   cnt_q [NumVC];
    logic                  credit_ok, consume_ok;
    logic [NumVCWidth-1:0] credit_idx, consume_idx;
    logic [NumVC-1:0]      hit_credit, hit_consume;
    logic [NumVC-1:0]      inc, dec;
    logic [NumVC-1:0]      at_full, at_empty;

    // Ids outside the VC range are dropped; only the low bits index a VC.
    assign credit_ok   = 32'(credit_id_i) < 32'(NumVC);
    assign consume_ok  = 32'(consume_id_i) < 32'(NumVC);
    assign credit_idx  = credit_id_i[NumVCWidth-1:0];
    assign consume_idx = consume_id_i[NumVCWidth-1:0];

    // Decode credit/consume events per VC; a same-cycle pair cancels out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hit_credit  = '0;
        hit_consume = '0;
        for (int v = 0; v < NumVC; v++) begin
            hit_credit[v]  = credit_v_i  && credit_ok  && (credit_idx  == NumVCWidth'(v));
            hit_consume[v] = consume_v_i && consume_ok && (consume_idx == NumVCWidth'(v));
            at_full[v]     = (cnt_q[v] == CntFull);
            at_empty[v]    = (cnt_q[v] == '0);
        end
        inc = hit_credit & ~hit_consume;
        dec = hit_consume & ~hit_credit;
    end

    // Saturating credit counters, reloaded to full depth on reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        // NOTE: the counter array is a small register file, not RAM, so it is reset.
        if (rst_i) begin
            for (int v = 0; v < NumVC; v++) cnt_q[v] <= CntFull;
        end else begin
            for (int v = 0; v < NumVC; v++) begin
                if (inc[v] && !at_full[v]) begin
                    cnt_q[v] <= cnt_q[v] + 1'b1;
                end else if (dec[v] && !at_empty[v]) begin
                    cnt_q[v] <= cnt_q[v] - 1'b1;
                end
            end
        end
    end

    // Per-VC availability straight from the registered counters.
    always_comb begin
        vc_not_empty_o = '0;
        for (int v = 0; v < NumVC; v++) vc_not_empty_o[v] = !at_empty[v];
    end

    // For each preferred VC pick itself or the next non-empty VC, wrapping around.
    always_comb begin
        vc_selection_v_o  = '0;
        vc_selection_id_o = '0;
        for (int p = 0; p < NumVC; p++) begin
            vc_selection_id_o[p] = NumVCWidthMax'(p);
            for (int k = 0; k < NumVC; k++) begin
                if (!vc_selection_v_o[p] && vc_not_empty_o[(p + k) % NumVC]) begin
                    vc_selection_v_o[p]  = 1'b1;
                    vc_selection_id_o[p] = NumVCWidthMax'((p + k) % NumVC);
                end
            end
        end
    end

`ifdef FLOO_VC_CREDIT_CHECK_EN
    logic err_q;

    // Sticky flag: any consume on an empty VC or credit on a full VC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (|((dec & at_empty) | (inc & at_full))) begin
            err_q <= 1'b1;
        end
    end

    assign credit_err_o = err_q;
`else
    assign credit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_vc_credit_selection.sv
// Directed, table-driven bench for floo_vc_credit_selection with
// NumVC=4, VCDepth=3 and a 3-bit external VC id (so out-of-range ids exist).
// The credit_err_o expectation follows FLOO_VC_CREDIT_CHECK_EN.
module tb_floo_vc_credit_selection;

    localparam int NumVC         = 4;
    localparam int NumVCWidthMax = 3;
    localparam int VCDepth       = 3;
`ifdef FLOO_VC_CREDIT_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        cv;
        logic [2:0]  cid;
        logic        sv;
        logic [2:0]  sid;
        logic [3:0]  exp_ne;
        logic [3:0]  exp_sel_v;
        logic [11:0] exp_sel_id;
        logic        exp_err;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        credit_v_i;
    logic [2:0]  credit_id_i;
    logic        consume_v_i;
    logic [2:0]  consume_id_i;
    logic [3:0]  vc_selection_v_o;
    logic [3:0][2:0] vc_selection_id_o;
    logic [3:0]  vc_not_empty_o;
    logic        credit_err_o;

    int n_pass = 0;
    int n_total = 0;
    vec_t vecs [23];

    floo_vc_credit_selection #(
        .NumVC(NumVC),
        .NumVCWidthMax(NumVCWidthMax),
        .VCDepth(VCDepth)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .credit_v_i(credit_v_i),
        .credit_id_i(credit_id_i),
        .consume_v_i(consume_v_i),
        .consume_id_i(consume_id_i),
        .vc_selection_v_o(vc_selection_v_o),
        .vc_selection_id_o(vc_selection_id_o),
        .vc_not_empty_o(vc_not_empty_o),
        .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [11:0] ids(input int a3, input int a2, input int a1, input int a0);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic cv, input int cid,
                                input logic sv, input int sid, input logic [3:0] ne,
                                input logic [3:0] selv, input logic [11:0] selid,
                                input logic err);
        vec_t t;
        t.rst = rst; t.cv = cv; t.cid = 3'(cid); t.sv = sv; t.sid = 3'(sid);
        t.exp_ne = ne; t.exp_sel_v = selv; t.exp_sel_id = selid; t.exp_err = err;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic rst, input logic cv, input logic [2:0] cid,
                        input logic sv, input logic [2:0] sid);
        rst_i = rst; credit_v_i = cv; credit_id_i = cid;
        consume_v_i = sv; consume_id_i = sid;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; credit_v_i = 1'b0; consume_v_i = 1'b0;
        credit_id_i = '0; consume_id_i = '0;
    endtask

    initial begin
        logic [11:0] idn;
        logic [11:0] id_2;
        logic [11:0] id_3;
        logic [11:0] id_0;
        idn  = ids(3, 2, 1, 0);
        id_2 = ids(3, 2, 2, 0);
        id_3 = ids(3, 3, 3, 0);
        id_0 = ids(0, 0, 0, 0);

        // reset, then drain VC1, VC2, VC3, VC0 in turn
        vecs[0]  = mk(1, 0, 0, 0, 0, 4'b1111, 4'b1111, idn,  0);
        vecs[1]  = mk(0, 0, 0, 1, 1, 4'b1111, 4'b1111, idn,  0);
        vecs[2]  = mk(0, 0, 0, 1, 1, 4'b1111, 4'b1111, idn,  0);
        vecs[3]  = mk(0, 0, 0, 1, 1, 4'b1101, 4'b1111, id_2, 0);
        vecs[4]  = mk(0, 0, 0, 1, 2, 4'b1101, 4'b1111, id_2, 0);
        vecs[5]  = mk(0, 0, 0, 1, 2, 4'b1101, 4'b1111, id_2, 0);
        vecs[6]  = mk(0, 0, 0, 1, 2, 4'b1001, 4'b1111, id_3, 0);
        vecs[7]  = mk(0, 0, 0, 1, 3, 4'b1001, 4'b1111, id_3, 0);
        vecs[8]  = mk(0, 0, 0, 1, 3, 4'b1001, 4'b1111, id_3, 0);
        vecs[9]  = mk(0, 0, 0, 1, 3, 4'b0001, 4'b1111, id_0, 0);
        vecs[10] = mk(0, 0, 0, 1, 0, 4'b0001, 4'b1111, id_0, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 4'b0001, 4'b1111, id_0, 0);
        vecs[12] = mk(0, 0, 0, 1, 0, 4'b0000, 4'b0000, idn,  0);
        // credit+consume on empty VC2 cancels; underflow on VC0; sticky flag
        vecs[13] = mk(0, 1, 2, 1, 2, 4'b0000, 4'b0000, idn,  0);
        vecs[14] = mk(0, 0, 0, 1, 0, 4'b0000, 4'b0000, idn,  1);
        vecs[15] = mk(0, 1, 0, 0, 0, 4'b0001, 4'b1111, id_0, 1);
        // reset dominates in-flight traffic; overflow on VC3 saturates
        vecs[16] = mk(1, 1, 1, 1, 0, 4'b1111, 4'b1111, idn,  0);
        vecs[17] = mk(0, 1, 3, 0, 0, 4'b1111, 4'b1111, idn,  1);
        // out-of-range credit id 5 must not touch VC1
        vecs[18] = mk(1, 0, 0, 0, 0, 4'b1111, 4'b1111, idn,  0);
        vecs[19] = mk(0, 0, 0, 1, 1, 4'b1111, 4'b1111, idn,  0);
        vecs[20] = mk(0, 0, 0, 1, 1, 4'b1111, 4'b1111, idn,  0);
        vecs[21] = mk(0, 0, 0, 1, 1, 4'b1101, 4'b1111, id_2, 0);
        vecs[22] = mk(0, 1, 5, 0, 0, 4'b1101, 4'b1111, id_2, 0);

        rst_i = 1'b0; credit_v_i = 1'b0; credit_id_i = '0;
        consume_v_i = 1'b0; consume_id_i = '0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rst, vecs[i].cv, vecs[i].cid, vecs[i].sv, vecs[i].sid);
            check($sformatf("v%0d not_empty", i), 32'(vc_not_empty_o), 32'(vecs[i].exp_ne));
            check($sformatf("v%0d sel_v", i), 32'(vc_selection_v_o), 32'(vecs[i].exp_sel_v));
            check($sformatf("v%0d sel_id", i), 32'(vc_selection_id_o), 32'(vecs[i].exp_sel_id));
            check($sformatf("v%0d err", i), 32'(credit_err_o), 32'(vecs[i].exp_err & ErrEn));
        end

        // Refill VC1 from 0 with four credits: the fourth overflows and must saturate at 3.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd1, 1'b0, 3'd0);
        check("refill not_empty", 32'(vc_not_empty_o), 32'(4'b1111));
        check("refill err", 32'(credit_err_o), 32'(ErrEn));
        // Exactly three consumes empty it again.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd0, 1'b1, 3'd1);
            check($sformatf("drain%0d vc1", i), 32'(vc_not_empty_o[1]), 32'(i < 2));
        end
        check("drain sel_id1", 32'(vc_selection_id_o[1]), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
